// File: rtl/spi_disp_pkg.sv
// Shared ST7735R SPI display definitions: command opcodes, read-responder
// state encoding and response lengths, used by the receive slave and the read responder.
package spi_disp_pkg;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_RDDID   = 8'h04;
  localparam logic [7:0] CMD_RDDST   = 8'h09;
  localparam logic [7:0] CMD_RDDPM   = 8'h0A;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RDID1   = 8'hDA;
  localparam logic [7:0] CMD_RDID2   = 8'hDB;
  localparam logic [7:0] CMD_RDID3   = 8'hDC;

  localparam logic [1:0] CMD   = 2'd0;
  localparam logic [1:0] DUMMY = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  localparam logic [5:0] LEN_RDDID = 6'd24;
  localparam logic [5:0] LEN_RDDST = 6'd32;
  localparam logic [5:0] LEN_BYTE  = 6'd8;

endpackage

// File: rtl/spi_read_responder.sv
// ST7735R read responder on the SPI clock: first MISO bit at posedge 9 (posedge 10 with dummy clock).
// No backpressure; the SPI master owns the clock, and CS high resets the block through i_rst_n.
module spi_read_responder
  import spi_disp_pkg::*;
#(
  parameter logic [7:0] P_ID1 = 8'h7C,
  parameter logic [7:0] P_ID2 = 8'h89,
  parameter logic [7:0] P_ID3 = 8'hF0
) (
  input  logic        i_spi_clk,
  input  logic        i_rst_n,
  input  logic        i_spi_cs,
  input  logic        i_spi_mosi,
  input  logic        i_dc,
  input  logic [31:0] i_status,
  input  logic [7:0]  i_power_mode,
  output logic        o_spi_miso,
  output logic        o_miso_oe
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [5:0]  remaining_q, remaining_d;
  logic [31:0] tx_q, tx_d;
  logic        miso_q;

  logic [7:0]  cmd_byte;
  logic        cmd_done;

  assign cmd_byte = {shift_q, i_spi_mosi};
  // Only command-phase bytes are decoded; data bytes are write payload.
  assign cmd_done = (state_q == CMD) && (bit_cnt_q == 3'd7) && !i_dc;

  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CMD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CMD: begin
        if (cmd_done) begin
          case (cmd_byte)
            CMD_RDDID, CMD_RDDST:                       state_d = DUMMY;
            CMD_RDDPM, CMD_RDID1, CMD_RDID2, CMD_RDID3: state_d = SHIFT;
            default:                                    state_d = CMD;
          endcase
        end
      end
      DUMMY:   state_d = SHIFT;
      SHIFT:   if (remaining_q == 6'd1) state_d = CMD;
      default: state_d = CMD;
    endcase
  end

  always_comb begin
    o_miso_oe = (state_q == SHIFT) && !i_spi_cs;
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    tx_d        = tx_q;
    case (state_q)
      CMD: begin
        shift_d   = cmd_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (cmd_done) begin
          case (cmd_byte)
            CMD_RDDID: begin
              tx_d        = {P_ID1, P_ID2, P_ID3, 8'h00};
              remaining_d = LEN_RDDID;
            end
            CMD_RDDST: begin
              tx_d        = i_status;
              remaining_d = LEN_RDDST;
            end
            CMD_RDDPM: begin
              tx_d        = {i_power_mode, 24'h0};
              remaining_d = LEN_BYTE;
            end
            CMD_RDID1: begin
              tx_d        = {P_ID1, 24'h0};
              remaining_d = LEN_BYTE;
            end
            CMD_RDID2: begin
              tx_d        = {P_ID2, 24'h0};
              remaining_d = LEN_BYTE;
            end
            CMD_RDID3: begin
              tx_d        = {P_ID3, 24'h0};
              remaining_d = LEN_BYTE;
            end
            default: ;
          endcase
        end
      end
      DUMMY: bit_cnt_d = 3'd0;
      SHIFT: begin
        bit_cnt_d   = 3'd0;
        tx_d        = {tx_q[30:0], 1'b0};
        remaining_d = remaining_q - 6'd1;
      end
      default: bit_cnt_d = 3'd0;
    endcase
  end

  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      remaining_q <= 6'd0;
      tx_q        <= 32'd0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      tx_q        <= tx_d;
    end
  end

  // Launch on the falling edge so the master sees a stable bit at its rising edge.
  always_ff @(negedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= (state_q == SHIFT) ? tx_q[31] : 1'b0;
    end
  end

  assign o_spi_miso = miso_q;

endmodule

// File: tb/tb_spi_read_responder.sv
// Scoreboard bench for spi_read_responder: expected {oe,miso} per SPI clock is queued
// when a command is driven and compared just before the master's sampling edge.
module tb_spi_read_responder;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        cs;
  logic        mosi;
  logic        dc;
  logic [31:0] status;
  logic [7:0]  power_mode;
  logic        rst_n;
  logic        miso;
  logic        oe;

  logic [1:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  string       tname    = "reset";

  always #5 clk = ~clk;

  assign rst_n = sys_rst_n & ~cs;

  spi_read_responder dut (
    .i_spi_clk    (clk),
    .i_rst_n      (rst_n),
    .i_spi_cs     (cs),
    .i_spi_mosi   (mosi),
    .i_dc         (dc),
    .i_status     (status),
    .i_power_mode (power_mode),
    .o_spi_miso   (miso),
    .o_miso_oe    (oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s/%s cyc=%0d got=%h expected=%h", tname, tag, cyc, got, exp);
    end
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b00);
  endtask

  task automatic expect_resp(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, w[31-i]});
  endtask

  // One SPI clock: master drives on the falling edge, samples before the rising edge.
  task automatic cycle(input logic c, input logic m, input logic d);
    logic [1:0] e;
    @(negedge clk);
    #1;
    cs   = c;
    mosi = m;
    dc   = d;
    #3;
    cyc++;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
      e = 2'b00;
    end else begin
      e = exp_q.pop_front();
    end
    check("oe", {31'd0, oe}, {31'd0, e[1]});
    check("miso", {31'd0, miso}, {31'd0, e[0]});
  endtask

  task automatic send(input logic [7:0] b, input logic d);
    for (int i = 7; i >= 0; i--) cycle(1'b0, b[i], d);
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) cycle(1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
  endtask

  task automatic cs_gap(input int n);
    expect_idle(n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    cs         = 1'b1;
    mosi       = 1'b0;
    dc         = 1'b0;
    status     = 32'hA5C3_0F81;
    power_mode = 8'h9C;

    cs_gap(2);
    sys_rst_n = 1'b1;
    cs_gap(2);

    tname = "rddid";
    expect_idle(9);
    expect_resp(32'h7C89_F000, 24);
    expect_idle(8);
    send(8'h04, 1'b0);
    run(25, 1'b1);
    run(8, 1'b0);
    cs_gap(2);

    tname = "rddst";
    expect_idle(9);
    expect_resp(32'hA5C3_0F81, 32);
    expect_idle(8);
    send(8'h09, 1'b0);
    run(33, 1'b1);
    run(8, 1'b0);
    cs_gap(2);

    tname = "rdid2_rdid3";
    expect_idle(8);
    expect_resp(32'h8900_0000, 8);
    expect_idle(8);
    expect_resp(32'hF000_0000, 8);
    expect_idle(8);
    send(8'hDB, 1'b0);
    run(8, 1'b1);
    send(8'hDC, 1'b0);
    run(8, 1'b1);
    run(8, 1'b0);
    cs_gap(2);

    tname = "data_byte";
    expect_idle(32);
    send(8'h2C, 1'b0);
    send(8'h04, 1'b1);
    run(16, 1'b0);
    cs_gap(2);

    tname = "abort";
    expect_idle(9);
    expect_resp(32'h7C89_F000, 10);
    send(8'h04, 1'b0);
    run(11, 1'b1);
    cs_gap(3);
    expect_idle(8);
    expect_resp(32'h7C00_0000, 8);
    expect_idle(8);
    send(8'hDA, 1'b0);
    run(8, 1'b1);
    run(8, 1'b0);
    cs_gap(2);

    tname = "undef_rddpm";
    expect_idle(16);
    expect_resp(32'h9C00_0000, 8);
    expect_idle(8);
    send(8'h55, 1'b0);
    send(8'h0A, 1'b0);
    run(8, 1'b1);
    run(8, 1'b0);
    cs_gap(2);

    tname = "end";
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_read_responder.md
Name: spi_read_responder

Overview:
- ST7735R read-command responder for the SPI display front end, clocked directly on the SPI clock.
- Sits beside the SPI receive/decode slave on the same MOSI/DC/CS wires and decodes command bytes independently.
- For supported read commands it drives MISO with ID or status bits using ST7735R read timing.
- Lets the host driver probe the panel (RDDID/RDDST) as if a real ST7735R were attached.

Parameters:
- P_ID1, 8'h7C, returned by RDID1 (0xDA) and as byte 0 of RDDID.
- P_ID2, 8'h89, returned by RDID2 (0xDB) and as byte 1 of RDDID.
- P_ID3, 8'hF0, returned by RDID3 (0xDC) and as byte 2 of RDDID.

Ports:
- i_spi_clk  in  1  SPI clock, mode 0; the block's only clock.
- i_rst_n  in  1  asynchronous, active-low reset. Top level drives it as sys_rst_n AND NOT spi_cs, so every CS-high clears the block.
- i_spi_cs  in  1  chip select, active-low; gates o_miso_oe.
- i_spi_mosi  in  1  MOSI.
- i_dc  in  1  H: data, L: command; sampled with the 8th bit of each byte.
- i_status  in  32  RDDST word. Quasi-static from the i_clk domain; sampled only at response load.
- i_power_mode  in  8  RDDPM byte. Quasi-static; sampled at load.
- o_spi_miso  out  1  MISO data; 0 whenever no response is active.
- o_miso_oe  out  1  MISO tri-state enable, high while shifting.

Behaviour:
- Reset (i_rst_n low, which includes CS high): state=CMD, bit_cnt=0, remaining=0, tx_reg=0, o_spi_miso=0. o_miso_oe is combinational, so it is 0.
- Receive logic runs on posedge i_spi_clk. o_spi_miso is a register updated on negedge i_spi_clk. Master samples MISO on posedge.
- State CMD:
  - Shift MOSI into an 8-bit register; 3-bit bit_cnt wraps 7->0.
  - On the 8th posedge with i_dc=0, decode {shift[6:0],mosi}:
    - 0x04 RDDID: load tx_reg={P_ID1,P_ID2,P_ID3,8'h00}, remaining=24, go to DUMMY.
    - 0x09 RDDST: load tx_reg=i_status, remaining=32, go to DUMMY.
    - 0x0A RDDPM: load tx_reg={i_power_mode,24'h0}, remaining=8, go to SHIFT.
    - 0xDA/0xDB/0xDC: load tx_reg={P_IDn,24'h0}, remaining=8, go to SHIFT.
    - Any other command: stay in CMD.
  - A byte completing with i_dc=1 is ignored (write payload) and the block stays in CMD.
- State DUMMY: one posedge consumed (the dummy clock), then go to SHIFT. MOSI is ignored.
- State SHIFT:
  - Each posedge: tx_reg<<=1, remaining-=1.
  - When remaining==1 at a posedge, that edge samples the last bit; go to CMD with bit_cnt=0.
  - MOSI is ignored and bit_cnt is held at 0.
- MISO output:
  - Negedge: o_spi_miso <= (state==SHIFT) ? tx_reg[31] : 0.
  - o_miso_oe = (state==SHIFT) & ~i_spi_cs.
- Latency:
  - No-dummy reads: the MSB is driven at the negedge after command bit 8 and sampled at posedge 9.
  - Dummy reads: the MSB is sampled at posedge 10.
- Remaining counter is 6 bits wide (max 32). Only SHIFT state decrements it.
- Reset mid-response (CS high or sys reset) aborts immediately: MISO=0, oe=0. The next transaction starts at CMD bit 0.
- Commands within one CS window are back-to-back: after SHIFT ends, the next 8 clocks form a new command byte.
- Clock edges with i_spi_cs high do not occur, because reset holds the block.

Decomposition:
- Shared package spi_disp_pkg:
  - ST7735R command constants: CMD_NOP, CMD_SWRESET, CMD_RDDID, CMD_RDDST, CMD_RDDPM, CMD_RDID1..3, CMD_CASET, CMD_RASET, CMD_RAMWR, CMD_DISPON/OFF.
  - State encoding localparams CMD/DUMMY/SHIFT.
  - Response-length constants.
- Command constants are reused by the receive/decode slave.
- No sub-module; the tx shift register is small enough to inline.

Test Plan:
- CS low, DC=0, send 0x04, then 25 clocks -> 1 dummy clock with MISO 0, then 24 bits 0x7C89F0 MSB first; oe high only during those 24 bits.
- Send 0x09 with i_status=32'hA5C3_0F81, then 33 clocks -> dummy bit, then 0xA5C30F81 sampled on posedge 10..41; oe low afterwards.
- Send 0xDB, then 8 clocks -> 0x89 with no dummy (MSB sampled at posedge 9). Follow in the same CS with 0xDC -> 0xF0.
- Send 0x2C with DC=0, then 0x04 with DC=1 -> no response, oe stays 0, MISO 0 throughout.
- Send 0x04, raise CS after 10 response bits, lower CS, send 0xDA -> first response aborts (MISO/oe 0 at CS high), second returns 0x7C aligned to the new byte.
- Send undefined 0x55, then 0x0A with i_power_mode=8'h9C -> no output for 0x55; 0x9C for 0x0A.
